// File: rtl/pulse_train_gen.sv
// pulse_train_gen: expands a one-cycle trigger into a train of N high phases
// of H cycles each, separated by low phases of L cycles each.
// The configuration is latched when the train starts. A configuration field
// of 0 is treated as 1. A trigger that arrives while a train is running is
// dropped and reported on overrun. Every output is driven directly by a flop.
module pulse_train_gen #(
    parameter int PH_BITS  = 8,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_pulse,
    input  logic [PH_BITS-1:0]  cfg_high,
    input  logic [PH_BITS-1:0]  cfg_low,
    input  logic [CNT_BITS-1:0] cfg_count,
    output logic                out_level,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_t;

    localparam logic [PH_BITS-1:0]  PH_ZERO  = {PH_BITS{1'b0}};
    localparam logic [PH_BITS-1:0]  PH_ONE   = {{(PH_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    // A phase length of 0 would mean an empty phase, so it is promoted to 1.
    function automatic logic [PH_BITS-1:0] ph_at_least_one(input logic [PH_BITS-1:0] v);
        return (v == PH_ZERO) ? PH_ONE : v;
    endfunction

    // A repeat count of 0 would mean an empty train, so it is promoted to 1.
    function automatic logic [CNT_BITS-1:0] cnt_at_least_one(input logic [CNT_BITS-1:0] v);
        return (v == CNT_ZERO) ? CNT_ONE : v;
    endfunction

    state_t              state_r;
    logic [PH_BITS-1:0]  high_len_r;
    logic [PH_BITS-1:0]  low_len_r;
    logic [CNT_BITS-1:0] rep_len_r;
    // The phase counter runs 1..length and the repeat counter runs 1..N.
    // Each counter is compared against its limit before it is incremented,
    // so neither one wraps, even at the all-ones limits.
    logic [PH_BITS-1:0]  phase_cnt_r;
    logic [CNT_BITS-1:0] rep_cnt_r;
    logic                out_level_r;
    logic                busy_r;
    logic                done_r;
    logic                overrun_r;

    assign out_level = out_level_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overrun   = overrun_r;

    // Train sequencer: state, counters, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            high_len_r  <= PH_ZERO;
            low_len_r   <= PH_ZERO;
            rep_len_r   <= CNT_ZERO;
            phase_cnt_r <= PH_ZERO;
            rep_cnt_r   <= CNT_ZERO;
            out_level_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_pulse) begin
                        high_len_r  <= ph_at_least_one(cfg_high);
                        low_len_r   <= ph_at_least_one(cfg_low);
                        rep_len_r   <= cnt_at_least_one(cfg_count);
                        phase_cnt_r <= PH_ONE;
                        rep_cnt_r   <= CNT_ONE;
                        state_r     <= ST_HIGH;
                        out_level_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        out_level_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    // A trigger during a running train is dropped and reported.
                    if (in_pulse) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= 1'b0;
                    end
                    if (phase_cnt_r == high_len_r) begin
                        if (rep_cnt_r == rep_len_r) begin
                            state_r     <= ST_IDLE;
                            phase_cnt_r <= PH_ZERO;
                            rep_cnt_r   <= CNT_ZERO;
                            out_level_r <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            state_r     <= ST_LOW;
                            phase_cnt_r <= PH_ONE;
                            out_level_r <= 1'b0;
                            busy_r      <= 1'b1;
                        end
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PH_ONE;
                        out_level_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_LOW: begin
                    // A trigger during a running train is dropped and reported.
                    if (in_pulse) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= 1'b0;
                    end
                    if (phase_cnt_r == low_len_r) begin
                        state_r     <= ST_HIGH;
                        phase_cnt_r <= PH_ONE;
                        rep_cnt_r   <= rep_cnt_r + CNT_ONE;
                        out_level_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PH_ONE;
                        out_level_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    phase_cnt_r <= PH_ZERO;
                    rep_cnt_r   <= CNT_ZERO;
                    out_level_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen. The reference model describes a train by its
// start cycle and its latched lengths. The expected outputs for any cycle are
// worked out from the waveform timing formula with plain arithmetic.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_pulse = 1'b0;
    logic [7:0] cfg_high = 8'd0;
    logic [7:0] cfg_low = 8'd0;
    logic [7:0] cfg_count = 8'd0;
    logic       out_level;
    logic       busy;
    logic       done;
    logic       overrun;

    pulse_train_gen #(.PH_BITS(8), .CNT_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pulse  (in_pulse),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
        .cfg_count (cfg_count),
        .out_level (out_level),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state: one train, described by its start and its lengths.
    bit have_train = 1'b0;
    int t0 = 0;
    int mh = 1;
    int ml = 1;
    int mn = 1;
    int t_end = 0;
    int ov_at = -1;

    int hi_cnt = 0;
    int done_cnt = 0;

    // Configuration the caller wants applied in the next stepped cycle.
    int d_h = 0;
    int d_l = 0;
    int d_n = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int m_busy(input int c);
        return (have_train && c > t0 && c <= t_end) ? 1 : 0;
    endfunction

    function automatic int m_out(input int c);
        if (m_busy(c) == 0) return 0;
        return (((c - t0 - 1) % (mh + ml)) < mh) ? 1 : 0;
    endfunction

    function automatic int m_done(input int c);
        return (have_train && c == t_end + 1) ? 1 : 0;
    endfunction

    // Advance one cycle: check the outputs, then apply new inputs and update the model.
    task automatic step(input logic r, input logic p);
        @(posedge clk);
        cyc++;
        #1;
        check_eq("out_level", int'(out_level), m_out(cyc));
        check_eq("busy", int'(busy), m_busy(cyc));
        check_eq("done", int'(done), m_done(cyc));
        check_eq("overrun", int'(overrun), (ov_at == cyc) ? 1 : 0);
        if (out_level) hi_cnt++;
        if (done) done_cnt++;
        if (r) begin
            have_train = 1'b0;
            ov_at = -1;
        end else if (p) begin
            if (m_busy(cyc) != 0) begin
                ov_at = cyc + 1;
            end else begin
                have_train = 1'b1;
                t0 = cyc;
                mh = (d_h == 0) ? 1 : d_h;
                ml = (d_l == 0) ? 1 : d_l;
                mn = (d_n == 0) ? 1 : d_n;
                t_end = t0 + mn * mh + (mn - 1) * ml;
            end
        end
        rst = r;
        in_pulse = p;
        cfg_high = d_h[7:0];
        cfg_low = d_l[7:0];
        cfg_count = d_n[7:0];
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0);
    endtask

    task automatic set_cfg(input int h, input int l, input int n);
        d_h = h;
        d_l = l;
        d_n = n;
    endtask

    initial begin
        // Reset is held from time 0, so the outputs are zero from cycle 1.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        idle(3);

        // Two phases of 3 cycles with a 2-cycle gap.
        set_cfg(3, 2, 2);
        step(1'b0, 1'b1);
        idle(12);

        // All-zero configuration behaves as a single 1-cycle pulse.
        set_cfg(0, 0, 0);
        step(1'b0, 1'b1);
        idle(5);

        // A second trigger during the train is dropped and reported on overrun.
        set_cfg(4, 4, 3);
        step(1'b0, 1'b1);
        idle(4);
        step(1'b0, 1'b1);
        idle(22);

        // A trigger in the done cycle starts a new train, with no overrun.
        set_cfg(2, 1, 1);
        step(1'b0, 1'b1);
        idle(2);
        step(1'b0, 1'b1);
        idle(5);

        // Reset mid-train aborts it and gives no done. A new pulse starts a clean train.
        set_cfg(5, 5, 4);
        step(1'b0, 1'b1);
        idle(9);
        step(1'b1, 1'b0);
        idle(4);
        step(1'b0, 1'b1);
        idle(40);

        // Configuration changes mid-train have no effect on the running train.
        set_cfg(3, 1, 2);
        step(1'b0, 1'b1);
        idle(1);
        set_cfg(7, 6, 9);
        idle(12);

        // A trigger held high for several cycles gives overrun on each later cycle.
        set_cfg(2, 2, 2);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(10);

        // Random triggers, resets, held pulses and configuration changes.
        for (int i = 0; i < 3000; i++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
        end
        idle(60);

        // Maximum-value run: both counters reach their all-ones limits.
        set_cfg(255, 1, 255);
        idle(2);
        hi_cnt = 0;
        done_cnt = 0;
        step(1'b0, 1'b1);
        idle(255 * 255 + 254 + 3);
        check_eq("max_high_cycles", hi_cnt, 65025);
        check_eq("max_done_count", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
